loop_addr_gen: RTL

- Consumes the loop-event stream of the loop controller: `loop_init`, `loop_enter`, `loop_exit`, `loop_index`, `loop_index_valid`, `loop_last_iter`, `stall`, `done`.
- Emits one buffer address per innermost iteration: address = base + Σ iter_k × stride_k.
- Keeps a per-loop stride table and a per-loop saved-offset stack, so nested loops rewind and advance correctly.
- Sits between the controller and each on-chip buffer read/write port; one instance per buffer.

---
 rtl/loop_addr_gen_pkg.sv | 18 +
 rtl/loop_addr_tbl.sv | 61 ++++++
 rtl/loop_addr_gen.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/loop_addr_gen_pkg.sv
// loop_addr_gen_pkg: shared state encoding and default widths for the loop
// address generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package loop_addr_gen_pkg;

  // Default widths; instances may override them through module parameters.
  localparam int DEF_LOOP_ID_W = 5;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_STRIDE_W  = 16;

  // Block state. IDLE must stay 0 so reset and the encoding agree.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/loop_addr_tbl.sv
// loop_addr_tbl: per-loop register file holding stride and saved offset,
// one write port per table, both read combinationally at one shared index.
// Latency: writes visible the cycle after the write; reads are same-cycle.
// Backpressure: none; every write is accepted.
//
// Ports:
//   clk, reset_n                              clock, async active-low reset
//   stride_we / stride_waddr / stride_wdat    stride table write port
//   offset_we / offset_waddr / offset_wdat    offset table write port
//   rd_idx                                    shared read index
//   stride_rd / offset_rd                     combinational read data
module loop_addr_tbl
  import loop_addr_gen_pkg::*;
#(
  parameter int LOOP_ID_W = DEF_LOOP_ID_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int STRIDE_W  = DEF_STRIDE_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stride_we,
  input  logic [LOOP_ID_W-1:0] stride_waddr,
  input  logic [STRIDE_W-1:0]  stride_wdat,
  input  logic                 offset_we,
  input  logic [LOOP_ID_W-1:0] offset_waddr,
  input  logic [ADDR_W-1:0]    offset_wdat,
  input  logic [LOOP_ID_W-1:0] rd_idx,
  output logic [STRIDE_W-1:0]  stride_rd,
  output logic [ADDR_W-1:0]    offset_rd
);

  localparam int DEPTH = 1 << LOOP_ID_W;

  logic [STRIDE_W-1:0] stride_tbl [DEPTH];
  logic [ADDR_W-1:0]   offset_tbl [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stride_tbl[i] <= '0;
      end
    end else if (stride_we) begin
      stride_tbl[stride_waddr] <= stride_wdat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        offset_tbl[i] <= '0;
      end
    end else if (offset_we) begin
      offset_tbl[offset_waddr] <= offset_wdat;
    end
  end

  // Reads see the pre-write contents on a same-cycle write to the same entry.
  assign stride_rd = stride_tbl[rd_idx];
  assign offset_rd = offset_tbl[rd_idx];

endmodule

// File: rtl/loop_addr_gen.sv
// loop_addr_gen: turns the loop controller's event stream into one buffer
// address per innermost iteration (base + sum of iter_k * stride_k).
// Latency: addr_out/addr_out_v registered, one cycle after the fire cycle;
// one address per cycle. Backpressure: stall suppresses the fire and
// addr_out holds its last value while addr_out_v drops.
//
// Build option: define LOOP_ADDR_GEN_BOUND_CHECK_EN to add the
// cfg_addr_limit input and the sticky addr_oob detector; otherwise addr_oob
// is tied low.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   cfg_base_addr_v / cfg_base_addr   base address load
//   cfg_addr_limit                    bound (bound-check builds only)
//   cfg_stride_v / cfg_stride / cfg_stride_loop_id   stride table write
//   loop_*, stall, done               controller event stream
//   addr_out / addr_out_v             generated address
//   addr_done, addr_busy, addr_oob    status
module loop_addr_gen
  import loop_addr_gen_pkg::*;
#(
  parameter int LOOP_ID_W = DEF_LOOP_ID_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int STRIDE_W  = DEF_STRIDE_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_base_addr_v,
  input  logic [ADDR_W-1:0]    cfg_base_addr,
`ifdef LOOP_ADDR_GEN_BOUND_CHECK_EN
  input  logic [ADDR_W-1:0]    cfg_addr_limit,
`endif
  input  logic                 cfg_stride_v,
  input  logic [STRIDE_W-1:0]  cfg_stride,
  input  logic [LOOP_ID_W-1:0] cfg_stride_loop_id,
  input  logic [LOOP_ID_W-1:0] loop_index,
  input  logic                 loop_index_valid,
  input  logic                 loop_last_iter,
  input  logic                 loop_init,
  input  logic                 loop_enter,
  input  logic                 loop_exit,
  input  logic                 stall,
  input  logic                 done,
  output logic [ADDR_W-1:0]    addr_out,
  output logic                 addr_out_v,
  output logic                 addr_done,
  output logic                 addr_busy,
  output logic                 addr_oob
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   base_q;

  logic [STRIDE_W-1:0] stride_rd;
  logic [ADDR_W-1:0]   offset_rd;
  logic [ADDR_W-1:0]   stride_ext;
  logic [ADDR_W-1:0]   step_addr;
  logic [ADDR_W-1:0]   exit_addr;

  logic                offset_we;
  logic [ADDR_W-1:0]   offset_wdat;

  logic                active;
  logic                fire;
  logic                exit_upd;

  // ---------------------------------------------------------------------
  // Stride / saved-offset tables, both read at the controller's loop_index
  // ---------------------------------------------------------------------
  loop_addr_tbl #(
    .LOOP_ID_W (LOOP_ID_W),
    .ADDR_W    (ADDR_W),
    .STRIDE_W  (STRIDE_W)
  ) u_tbl (
    .clk          (clk),
    .reset_n      (reset_n),
    .stride_we    (cfg_stride_v),
    .stride_waddr (cfg_stride_loop_id),
    .stride_wdat  (cfg_stride),
    .offset_we    (offset_we),
    .offset_waddr (loop_index),
    .offset_wdat  (offset_wdat),
    .rd_idx       (loop_index),
    .stride_rd    (stride_rd),
    .offset_rd    (offset_rd)
  );

  // Strides are unsigned; all sums wrap silently modulo 2^ADDR_W.
  assign stride_ext = ADDR_W'(stride_rd);
  assign step_addr  = addr_q + stride_ext;
  assign exit_addr  = offset_rd + stride_ext;

  assign active   = (state_q == ACTIVE);
  // A same-cycle exit takes precedence, so it also suppresses the fire.
  assign fire     = loop_index_valid && !stall && active && !loop_exit;
  // Exiting into a loop that still has iterations left: advance that loop's
  // saved offset by one of its strides and restart the running address there.
  assign exit_upd = loop_exit && !loop_last_iter;

  // ---------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (loop_init) state_d = ACTIVE;
      ACTIVE:  if (done)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Running address and offset-table update
  // Priority: loop_init > loop_exit > loop_enter for the single offset
  // write port; loop_init > loop_exit > fire for the running address.
  // ---------------------------------------------------------------------
  always_comb begin
    addr_d      = addr_q;
    offset_we   = 1'b0;
    offset_wdat = addr_q;
    if (loop_init) begin
      addr_d      = base_q;
      offset_we   = 1'b1;
      offset_wdat = base_q;
    end else begin
      if (exit_upd) begin
        addr_d      = exit_addr;
        offset_we   = 1'b1;
        offset_wdat = exit_addr;
      end else if (loop_enter) begin
        offset_we   = 1'b1;
        offset_wdat = addr_q;
      end
      // On the final iteration the address holds; the following exit
      // repositions it from the outer loop's saved offset.
      if (fire && !loop_last_iter) begin
        addr_d = step_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      base_q <= '0;
    end else begin
      addr_q <= addr_d;
      // loop_init in the same cycle has already consumed the old base_q.
      if (cfg_base_addr_v) begin
        base_q <= cfg_base_addr;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_out   <= '0;
      addr_out_v <= 1'b0;
      addr_done  <= 1'b0;
    end else begin
      addr_out_v <= fire;
      addr_done  <= done;
      if (fire) begin
        addr_out <= addr_q;
      end
    end
  end

  assign addr_busy = active;

  // ---------------------------------------------------------------------
  // Optional out-of-bounds detector
  // ---------------------------------------------------------------------
`ifdef LOOP_ADDR_GEN_BOUND_CHECK_EN
  logic [ADDR_W-1:0] limit_q;
  logic              oob_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      limit_q <= '0;
      oob_q   <= 1'b0;
    end else begin
      if (cfg_base_addr_v) begin
        limit_q <= cfg_addr_limit;
      end
      // Sticky until the next run starts.
      if (loop_init) begin
        oob_q <= 1'b0;
      end else if (fire && (addr_q >= limit_q)) begin
        oob_q <= 1'b1;
      end
    end
  end

  assign addr_oob = oob_q;
`else
  assign addr_oob = 1'b0;
`endif

endmodule
